// File: rtl/riscboy_ppu_span_sequencer_pkg.sv
// Shared PPU constants for the span sequencer and its address calculator:
// pixel mode encodings, pixel-size lookup and the sequencer state type.
package riscboy_ppu_span_sequencer_pkg;

  localparam logic [2:0] PIXMODE_ARGB1555 = 3'h0;
  localparam logic [2:0] PIXMODE_PAL8     = 3'h4;
  localparam logic [2:0] PIXMODE_PAL4     = 3'h5;
  localparam logic [2:0] PIXMODE_PAL1     = 3'h6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FETCH,
    ST_WAIT_ACK
  } span_state_t;

  // log2 of bits per pixel; unknown modes fall back to 16bpp
  function automatic logic [2:0] mode_log_pixsize(input logic [2:0] mode);
    case (mode)
      PIXMODE_PAL8: return 3'd3;
      PIXMODE_PAL4: return 3'd2;
      PIXMODE_PAL1: return 3'd0;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_ppu_span_sequencer_if.sv
// Command, bus-master and pixel-streamer signals of the span sequencer.
// master = sequencer side, slave = scheduler/bus/streamer side.
interface riscboy_ppu_span_sequencer_if #(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_SHIFTCTR = $clog2(W_DATA),
  parameter int W_XOFF     = 10,
  parameter int W_COUNT    = 9
);

  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [W_ADDR-1:0]     cmd_addr;
  logic [W_XOFF-1:0]     cmd_xoff;
  logic [W_COUNT-1:0]    cmd_count;
  logic [2:0]            cmd_pixmode;

  logic                  bus_req;
  logic [W_ADDR-1:0]     bus_addr;
  logic                  bus_ack;
  logic [W_DATA-1:0]     bus_rdata;

  logic                  strm_flush;
  logic                  strm_flush_unaligned;
  logic [W_SHIFTCTR-1:0] strm_seek_target;
  logic [2:0]            strm_pixel_mode;
  logic                  strm_load_req;
  logic                  strm_load_ack;
  logic [W_DATA-1:0]     strm_load_data;
  logic                  strm_pix_vld;
  logic                  strm_pix_rdy;

  modport master (
    input  cmd_vld, cmd_addr, cmd_xoff, cmd_count, cmd_pixmode,
    input  bus_ack, bus_rdata,
    input  strm_load_req, strm_pix_vld, strm_pix_rdy,
    output cmd_rdy, bus_req, bus_addr,
    output strm_flush, strm_flush_unaligned, strm_seek_target, strm_pixel_mode,
    output strm_load_ack, strm_load_data
  );

  modport slave (
    output cmd_vld, cmd_addr, cmd_xoff, cmd_count, cmd_pixmode,
    output bus_ack, bus_rdata,
    output strm_load_req, strm_pix_vld, strm_pix_rdy,
    input  cmd_rdy, bus_req, bus_addr,
    input  strm_flush, strm_flush_unaligned, strm_seek_target, strm_pixel_mode,
    input  strm_load_ack, strm_load_data
  );

endinterface

// File: rtl/riscboy_ppu_span_addr_calc.sv
// Combinational span start math: first word address and bit seek offset
// of a pixel within a row. Shared with the tile fetcher.
module riscboy_ppu_span_addr_calc
  import riscboy_ppu_span_sequencer_pkg::*;
#(
  parameter int W_ADDR     = 32,
  parameter int W_XOFF     = 10,
  parameter int W_SHIFTCTR = 5
) (
  input  logic [W_ADDR-1:0]     base_addr,
  input  logic [W_XOFF-1:0]     xoff,
  input  logic [2:0]            pixmode,
  output logic [W_ADDR-1:0]     start_addr,
  output logic [W_SHIFTCTR-1:0] seek,
  output logic                  unaligned
);

  localparam int W_BITOFF = W_XOFF + 4;

  logic [W_BITOFF-1:0] bitoff;

  assign bitoff     = W_BITOFF'(xoff) << mode_log_pixsize(pixmode);
  // Whole words skipped become a byte offset on the word-aligned base
  assign start_addr = {base_addr[W_ADDR-1:2], 2'b00}
                    + (W_ADDR'(bitoff >> W_SHIFTCTR) << 2);
  assign seek       = bitoff[W_SHIFTCTR-1:0];
  assign unaligned  = |seek;

endmodule

// File: rtl/riscboy_ppu_span_sequencer.sv
// Drives one pixel streamer across a horizontal span: flush/seek at start,
// word reads on streamer demand, pixel counting and retirement.
module riscboy_ppu_span_sequencer
  import riscboy_ppu_span_sequencer_pkg::*;
#(
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_SHIFTCTR = $clog2(W_DATA),
  parameter int W_XOFF     = 10,
  parameter int W_COUNT    = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  output logic done,
  riscboy_ppu_span_sequencer_if.master sif
);

  span_state_t state, next_state;

  logic                  cmd_rdy_q;
  logic                  done_q;
  logic                  bus_req_q;
  logic                  ack_last;
  logic [W_ADDR-1:0]     bus_addr_q;
  logic [W_COUNT-1:0]    pix_remaining;
  logic                  unaligned_q;
  logic [W_SHIFTCTR-1:0] seek_q;
  logic [2:0]            pixmode_q;

  logic [W_ADDR-1:0]     calc_addr;
  logic [W_SHIFTCTR-1:0] calc_seek;
  logic                  calc_unaligned;

  logic accept, pix_hs, retire, bus_done, req_pending, req_start;

  riscboy_ppu_span_addr_calc #(
    .W_ADDR     (W_ADDR),
    .W_XOFF     (W_XOFF),
    .W_SHIFTCTR (W_SHIFTCTR)
  ) u_addr_calc (
    .base_addr  (sif.cmd_addr),
    .xoff       (sif.cmd_xoff),
    .pixmode    (sif.cmd_pixmode),
    .start_addr (calc_addr),
    .seek       (calc_seek),
    .unaligned  (calc_unaligned)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (accept) next_state = ST_FLUSH;
      ST_FLUSH:    next_state = abort ? ST_IDLE : ST_FETCH;
      ST_FETCH:    if (abort || retire)
                     next_state = req_pending ? ST_WAIT_ACK : ST_IDLE;
      ST_WAIT_ACK: if (bus_done) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == ST_IDLE) && cmd_rdy_q && sif.cmd_vld && !abort;
    pix_hs      = (state == ST_FETCH) && sif.strm_pix_vld && sif.strm_pix_rdy;
    retire      = pix_hs && (pix_remaining == '0);
    bus_done    = bus_req_q && sif.bus_ack;
    req_pending = bus_req_q && !sif.bus_ack;
    // load_req lags the streamer's consumption of the last word by a cycle
    req_start   = (state == ST_FETCH) && (next_state == ST_FETCH) &&
                  sif.strm_load_req && !bus_req_q && !ack_last;

    sif.cmd_rdy              = cmd_rdy_q;
    sif.bus_req              = bus_req_q;
    sif.bus_addr             = bus_addr_q;
    sif.strm_flush           = (state == ST_FLUSH);
    sif.strm_flush_unaligned = (state == ST_FLUSH) && unaligned_q;
    sif.strm_seek_target     = seek_q;
    sif.strm_pixel_mode      = pixmode_q;
    sif.strm_load_ack        = bus_done && (state == ST_FETCH);
    sif.strm_load_data       = sif.bus_rdata;
    done                     = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_rdy_q     <= 1'b0;
      done_q        <= 1'b0;
      bus_req_q     <= 1'b0;
      ack_last      <= 1'b0;
      bus_addr_q    <= '0;
      pix_remaining <= '0;
      unaligned_q   <= 1'b0;
      seek_q        <= '0;
      pixmode_q     <= 3'd0;
    end else begin
      cmd_rdy_q <= (next_state == ST_IDLE);
      done_q    <= retire && !abort;
      ack_last  <= bus_done;

      if (accept) begin
        bus_addr_q    <= calc_addr;
        pix_remaining <= sif.cmd_count;
        unaligned_q   <= calc_unaligned;
        seek_q        <= calc_seek;
        pixmode_q     <= sif.cmd_pixmode;
      end

      if (pix_hs && (pix_remaining != '0))
        pix_remaining <= pix_remaining - 1'b1;

      if (bus_done) begin
        bus_req_q  <= 1'b0;
        bus_addr_q <= bus_addr_q + W_ADDR'(4);
      end else if (req_start) begin
        bus_req_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_span_sequencer.sv
// Directed bench for the span sequencer: a table of spans with hand-computed
// addresses/seeks/read counts, plus abort, reset and command-collision cases.
module tb_riscboy_ppu_span_sequencer;
  import riscboy_ppu_span_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic done;

  int checks = 0;
  int errors = 0;

  riscboy_ppu_span_sequencer_if sif ();

  riscboy_ppu_span_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .done  (done),
    .sif   (sif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pixmode;
    logic [31:0] addr;
    logic [9:0]  xoff;
    logic [8:0]  count;
    logic [31:0] exp_addr;
    logic [4:0]  exp_seek;
    logic        exp_unal;
    int          reads;
    int          ack_delay;
    int          bp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cmd_rdy();
    int n = 0;
    while (!sif.cmd_rdy && n < 20) begin
      cyc();
      n++;
    end
    check("cmd_rdy_wait", sif.cmd_rdy, 1);
  endtask

  task automatic drive_cmd(input vec_t v);
    sif.cmd_addr    = v.addr;
    sif.cmd_xoff    = v.xoff;
    sif.cmd_count   = v.count;
    sif.cmd_pixmode = v.pixmode;
    sif.cmd_vld     = 1'b1;
  endtask

  task automatic check_flush(input vec_t v);
    check("flush",           sif.strm_flush, 1);
    check("flush_unaligned", sif.strm_flush_unaligned, v.exp_unal);
    check("seek_target",     sif.strm_seek_target, v.exp_seek);
    check("pixel_mode",      sif.strm_pixel_mode, v.pixmode);
    check("cmd_rdy_busy",    sif.cmd_rdy, 0);
    check("no_req_in_flush", sif.bus_req, 0);
  endtask

  // Accept a command and step through FLUSH; returns on the first FETCH negedge
  task automatic do_accept(input vec_t v);
    wait_cmd_rdy();
    drive_cmd(v);
    cyc();
    sif.cmd_vld = 1'b0;
    check_flush(v);
    cyc();
    check("flush_one_cycle", sif.strm_flush, 0);
  endtask

  task automatic do_reads(input vec_t v);
    logic [31:0] rd;
    sif.strm_load_req = 1'b1;
    for (int r = 0; r < v.reads; r++) begin
      int n = 0;
      while (!sif.bus_req && n < 8) begin
        cyc();
        n++;
      end
      check("req_latency", n, (r == 0) ? 1 : 2);
      check("bus_addr", sif.bus_addr, v.exp_addr + 32'(4 * r));
      for (int d = 0; d < v.ack_delay; d++) begin
        cyc();
        check("req_held", sif.bus_req, 1);
        check("addr_stable", sif.bus_addr, v.exp_addr + 32'(4 * r));
      end
      rd = 32'hC0DE_0000 ^ 32'(r * 32'h111);
      sif.bus_rdata = rd;
      sif.bus_ack   = 1'b1;
      if (r == v.reads - 1) sif.strm_load_req = 1'b0;
      #1;
      check("load_ack", sif.strm_load_ack, 1);
      check("load_data", sif.strm_load_data, rd);
      cyc();
      sif.bus_ack = 1'b0;
    end
    check("req_dropped", sif.bus_req, 0);
    check("addr_advanced", sif.bus_addr, v.exp_addr + 32'(4 * v.reads));
  endtask

  task automatic do_pixels(input vec_t v);
    for (int i = 0; i <= int'(v.count); i++) begin
      if (v.bp > 0 && i == 1) begin
        sif.strm_pix_vld = 1'b1;
        sif.strm_pix_rdy = 1'b0;
        for (int b = 0; b < v.bp; b++) begin
          cyc();
          check("bp_no_done", done, 0);
          check("bp_no_req", sif.bus_req, 0);
        end
      end
      sif.strm_pix_vld = 1'b1;
      sif.strm_pix_rdy = 1'b1;
      cyc();
      check("done_timing", done, (i == int'(v.count)));
    end
    sif.strm_pix_vld = 1'b0;
    sif.strm_pix_rdy = 1'b0;
    cyc();
    check("done_pulse", done, 0);
    check("cmd_rdy_after_done", sif.cmd_rdy, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_rdy",   sif.cmd_rdy, 0);
    check("rst_done",      done, 0);
    check("rst_bus_req",   sif.bus_req, 0);
    check("rst_bus_addr",  sif.bus_addr, 0);
    check("rst_flush",     sif.strm_flush, 0);
    check("rst_unaligned", sif.strm_flush_unaligned, 0);
    check("rst_seek",      sif.strm_seek_target, 0);
    check("rst_pixmode",   sif.strm_pixel_mode, 0);
    check("rst_load_ack",  sif.strm_load_ack, 0);
  endtask

  always @(posedge clk) begin
    if (!rst)
      assert (!(sif.bus_ack && !sif.bus_req))
      else begin
        errors++;
        $display("FAIL bus_ack_without_req: ack=1 req=0 (t=%0t)", $time);
      end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           mode              addr          xoff     count   exp_addr      seek   unal  rd  dly bp
    vecs[0] = '{PIXMODE_ARGB1555, 32'h0000_1000, 10'd0,    9'd3,   32'h0000_1000, 5'd0,  1'b0, 2,   0, 0};
    vecs[1] = '{PIXMODE_PAL4,     32'h0000_2000, 10'd13,   9'd15,  32'h0000_2004, 5'd20, 1'b1, 3,   0, 0};
    vecs[2] = '{PIXMODE_ARGB1555, 32'h0000_3000, 10'd0,    9'd7,   32'h0000_3000, 5'd0,  1'b0, 4,   1, 10};
    vecs[3] = '{PIXMODE_PAL8,     32'h0000_4003, 10'd5,    9'd2,   32'h0000_4004, 5'd8,  1'b1, 1,   3, 0};
    vecs[4] = '{PIXMODE_PAL1,     32'hFFFF_FFFC, 10'd1023, 9'd0,   32'h0000_0078, 5'd31, 1'b1, 1,   0, 0};
    vecs[5] = '{PIXMODE_ARGB1555, 32'h0001_0000, 10'd1023, 9'd1,   32'h0001_07FC, 5'd16, 1'b1, 2,   2, 0};
    vecs[6] = '{PIXMODE_PAL8,     32'h0000_5000, 10'd0,    9'd511, 32'h0000_5000, 5'd0,  1'b0, 128, 0, 0};

    rst = 1'b1;
    abort = 1'b0;
    sif.cmd_vld = 1'b0;
    sif.cmd_addr = '0;
    sif.cmd_xoff = '0;
    sif.cmd_count = '0;
    sif.cmd_pixmode = '0;
    sif.bus_ack = 1'b0;
    sif.bus_rdata = '0;
    sif.strm_load_req = 1'b0;
    sif.strm_pix_vld = 1'b0;
    sif.strm_pix_rdy = 1'b0;

    cyc();
    cyc();
    check_reset_outputs();
    rst = 1'b0;
    cyc();
    check("cmd_rdy_after_reset", sif.cmd_rdy, 1);

    for (int k = 0; k < 7; k++) begin
      do_accept(vecs[k]);
      do_reads(vecs[k]);
      do_pixels(vecs[k]);
    end

    // Command and abort together in IDLE: abort wins, command retried next cycle
    wait_cmd_rdy();
    drive_cmd(vecs[0]);
    abort = 1'b1;
    cyc();
    check("collide_no_flush", sif.strm_flush, 0);
    check("collide_cmd_rdy", sif.cmd_rdy, 1);
    abort = 1'b0;
    cyc();
    sif.cmd_vld = 1'b0;
    check_flush(vecs[0]);
    cyc();
    do_reads(vecs[0]);
    do_pixels(vecs[0]);

    // Abort with a request outstanding: request held, ack swallowed, no done
    do_accept(vecs[3]);
    sif.strm_load_req = 1'b1;
    cyc();
    check("abort_req_up", sif.bus_req, 1);
    sif.strm_load_req = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    for (int d = 0; d < 5; d++) begin
      check("abort_req_held", sif.bus_req, 1);
      check("abort_cmd_rdy", sif.cmd_rdy, 0);
      check("abort_no_done", done, 0);
      abort = (d == 2);
      cyc();
    end
    abort = 1'b0;
    sif.bus_rdata = 32'hDEAD_BEEF;
    sif.bus_ack = 1'b1;
    #1;
    check("abort_ack_swallowed", sif.strm_load_ack, 0);
    cyc();
    sif.bus_ack = 1'b0;
    check("abort_cmd_rdy_back", sif.cmd_rdy, 1);
    check("abort_req_gone", sif.bus_req, 0);
    check("abort_no_done_end", done, 0);

    // Reset in FETCH with a request pending, then a clean span
    do_accept(vecs[1]);
    sif.strm_load_req = 1'b1;
    cyc();
    check("midrst_req_up", sif.bus_req, 1);
    rst = 1'b1;
    sif.strm_load_req = 1'b0;
    cyc();
    check_reset_outputs();
    rst = 1'b0;
    cyc();
    check("cmd_rdy_after_midrst", sif.cmd_rdy, 1);
    do_accept(vecs[0]);
    do_reads(vecs[0]);
    do_pixels(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscboy_ppu_span_sequencer.md
Name: riscboy_ppu_span_sequencer

Overview:
Sequences one pixel streamer instance through a horizontal span of pixels. It accepts span commands from the PPU scanline/sprite scheduler: row base address, starting pixel offset, pixel count and pixel mode. For each command it computes the start word address and the bit seek target, flushes the streamer, and services the streamer's load requests with word-aligned bus reads. It counts consumed pixels and retires the span. It sits between the scheduler, the PPU bus master port and the pixel streamer.

Parameters:
W_ADDR, 32, bus byte address width
W_DATA, 32, bus/streamer data width; only 32 is supported
W_SHIFTCTR, $clog2(W_DATA), streamer seek target width (driven)
W_XOFF, 10, width of starting pixel offset
W_COUNT, 9, width of pixel count field (count-1 encoding)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_vld  in  1  span command valid
cmd_rdy  out  1  span command accepted when vld&&rdy
cmd_addr  in  W_ADDR  row base byte address, word-aligned (bits [1:0] ignored)
cmd_xoff  in  W_XOFF  first pixel index within row
cmd_count  in  W_COUNT  pixels in span minus one
cmd_pixmode  in  3  pixel mode (PIXMODE_* encoding)
abort  in  1  kill current span (e.g. end of line)
done  out  1  one-cycle pulse when span retires normally
bus_req  out  1  read request, held until bus_ack
bus_addr  out  W_ADDR  word-aligned read address
bus_ack  in  1  read data valid this cycle, completes request
bus_rdata  in  W_DATA  read data
strm_flush  out  1  streamer flush
strm_flush_unaligned  out  1  streamer seek required
strm_seek_target  out  W_SHIFTCTR  streamer seek bit offset
strm_pixel_mode  out  3  registered pixel mode for streamer
strm_load_req  in  1  streamer wants a word
strm_load_ack  out  1  word delivered to streamer
strm_load_data  out  W_DATA  word to streamer
strm_pix_vld  in  1  tap of streamer out_vld
strm_pix_rdy  in  1  tap of streamer out_rdy

Behaviour:
- Reset (rst high at a clk edge) outputs: cmd_rdy=0 for the reset cycle, then 1 in IDLE. done=0, bus_req=0, bus_addr=0, strm_flush=0, strm_flush_unaligned=0, strm_seek_target=0, strm_pixel_mode=0, strm_load_ack=0. A reset mid-span drops any outstanding request; the bus interconnect is reset alongside.
- States: IDLE, FLUSH, FETCH, WAIT_ACK.
- IDLE: cmd_rdy=1. On cmd_vld && !abort, latch the command and go to FLUSH. If abort is high in the same cycle, abort wins and the command is not accepted.
- Address math at accept: bitoff = cmd_xoff << MODE_LOG_PIXSIZE(cmd_pixmode), zero-extended to W_XOFF+4 bits. addr = {cmd_addr[W_ADDR-1:2],2'b00} + ((bitoff >> 5) << 2), modulo 2^W_ADDR. seek = bitoff[4:0]. unaligned = |seek. pix_remaining = cmd_count.
- FLUSH: exactly one cycle. strm_flush=1, strm_flush_unaligned=unaligned, strm_seek_target=seek. strm_pixel_mode is updated on accept and held until the next accept. Next state is FETCH.
- FETCH: bus_req rises the cycle after strm_load_req=1 is sampled with no request pending. Requests are also held off for the cycle immediately after an ack, because the streamer's load_req lags by one cycle. bus_req and bus_addr are stable until bus_ack. On bus_ack: strm_load_ack=1 and strm_load_data=bus_rdata combinationally in the same cycle, bus_addr += 4, bus_req falls. At most one request is outstanding.
- Pixel counting: each cycle with strm_pix_vld && strm_pix_rdy in FETCH decrements pix_remaining. A handshake when pix_remaining==0 retires the span: pulse done next cycle, go to IDLE if no request is pending, else go to WAIT_ACK.
- WAIT_ACK: bus_req stays asserted (requests are never withdrawn). On bus_ack the data is discarded: strm_load_ack=0. Then go to IDLE. cmd_rdy=0 while in this state.
- abort in FLUSH or FETCH: go to IDLE, or to WAIT_ACK if bus_req is high. done is not pulsed. abort in WAIT_ACK has no effect.
- Pixel handshakes outside FETCH are ignored.
- bus_ack without bus_req is a protocol error. It is ignored and must be flagged by a bench assertion.
- Single span throughput: done → next cmd accepted ≥1 cycle later, because cmd_rdy is registered from state.

Decomposition:
- The PIXMODE_* constants and MODE_LOG_PIXSIZE come from the shared riscboy_ppu_const.vh include; do not duplicate them.
- Put state encodings as localparams in that same include if the scheduler needs to observe them; otherwise keep them local.
- Natural sub-module: riscboy_ppu_span_addr_calc, combinational, producing addr/seek/unaligned from cmd fields. It is reused by the tile fetcher.

Test Plan:
- Aligned 16bpp span: addr=0x1000, xoff=0, count=3 → one flush with unaligned=0, seek=0. Reads at 0x1000 and 0x1004. done exactly one cycle after the 4th pixel handshake.
- Unaligned 4bpp span: xoff=13 → bitoff=52, first addr=base+4, seek=20, unaligned=1. count=15 → 16 pixels consumed, reads base+4, base+8, base+0xC.
- Backpressure: strm_pix_rdy held low for 10 cycles mid-span → no extra bus_req, pix_remaining frozen, done timing shifts by 10 cycles.
- Abort with request pending: abort while bus_req=1, bus_ack delayed 5 cycles → bus_req held, strm_load_ack stays 0 on the ack, no done, cmd_rdy returns the cycle after the ack.
- Simultaneous cmd_vld and abort in IDLE → command not accepted, no flush. The same command presented next cycle without abort is accepted.
- Reset mid-FETCH → all outputs at reset values next cycle. A new command afterwards runs normally from a fresh flush.
